// File: rtl/sprite_pkg.sv
// sprite_pkg
//   Shared types and constants for the sprite blitter slice.
//   - state_t      : blitter sequencing states
//   - DEF_*        : default screen geometry and colour depth
//   - clip()       : true when a coordinate sum lies outside the visible area
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    DRAW,
    FLUSH,
    DONE
  } state_t;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_COLOR_W  = 3;

  // Sums arrive zero-extended, so a carry out of the coordinate width
  // simply shows up as a large value and is clipped like any other.
  function automatic logic clip(input logic [31:0] sum, input logic [31:0] limit);
    return sum >= limit;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter
//   Walks a W x H rectangle in raster order: col is the inner index, row
//   the outer one, addr = row*W + col kept as its own incrementing counter.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset
//     clear       : force back to pixel 0
//     step        : advance one pixel (wraps to 0 after the last pixel)
//     col, row    : current pixel position inside the rectangle
//     addr        : linear texel address of the current pixel
//     last        : current pixel is the final one of the rectangle
module raster_counter #(
  parameter int W      = 10,
  parameter int H      = 10,
  parameter int COL_W  = (W > 1) ? $clog2(W) : 1,
  parameter int ROW_W  = (H > 1) ? $clog2(H) : 1,
  parameter int ADDR_W = (W * H > 1) ? $clog2(W * H) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              step,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic col_end;

  assign col_end = (col == COL_W'(W - 1));
  assign last    = col_end && (row == ROW_W'(H - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (clear || (step && last)) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (step) begin
      addr <= addr + 1'b1;
      if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
//   On an accepted start, erases the previous sprite footprint to BG_COLOR
//   (skipped on the first draw after reset), then draws an SPR_W x SPR_H
//   sprite from a synchronous ROM at the new position. Off-screen pixels
//   and transparent texels are not plotted but still take their cycle.
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     start, new_x, new_y  : draw request and new top-left position
//     busy, done           : operation in progress / one-cycle completion
//     rom_addr, rom_data   : texel ROM interface (data one cycle after addr)
//     vga_x/y/colour/plot  : pixel write interface to the VGA adapter
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W        = 10,
  parameter int SPR_H        = 10,
  parameter int COORD_W      = 11,
  parameter int SCREEN_W     = DEF_SCREEN_W,
  parameter int SCREEN_H     = DEF_SCREEN_H,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int BG_COLOR     = 0,
  parameter int TRANSP_EN    = 1,
  parameter int TRANSP_COLOR = 7,
  parameter int ADDR_W       = $clog2(SPR_W * SPR_H)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COORD_W-1:0] new_x,
  input  logic [COORD_W-1:0] new_y,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COORD_W-1:0] vga_x,
  output logic [COORD_W-1:0] vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               vga_plot
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  state_t               state;
  logic                 flush_cnt;
  logic                 first_draw;
  logic [COORD_W-1:0]   lat_x, lat_y, old_x, old_y;
  logic [COORD_W-1:0]   base_x, base_y;
  logic [COORD_W:0]     x_sum, y_sum;
  logic                 pix_clip, transparent;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [ADDR_W-1:0]    cnt_addr;
  logic                 last, clear, step;
  logic [COORD_W-1:0]   d1_x, d1_y;
  logic                 d1_plot;

  raster_counter #(
    .W(SPR_W), .H(SPR_H), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
  ) u_raster (
    .clk(clk), .resetn(resetn), .clear(clear), .step(step),
    .col(col), .row(row), .addr(cnt_addr), .last(last)
  );

  assign clear    = (state == IDLE);
  assign step     = (state == ERASE) || (state == DRAW);
  assign rom_addr = cnt_addr;

  // Erase walks the old footprint, draw walks the latched new one.
  assign base_x = (state == ERASE) ? old_x : lat_x;
  assign base_y = (state == ERASE) ? old_y : lat_y;
  assign x_sum  = (COORD_W+1)'(base_x) + (COORD_W+1)'(col);
  assign y_sum  = (COORD_W+1)'(base_y) + (COORD_W+1)'(row);

  assign pix_clip    = clip(32'(x_sum), 32'(SCREEN_W)) | clip(32'(y_sum), 32'(SCREEN_H));
  assign transparent = (TRANSP_EN != 0) && (rom_data == COLOR_W'(TRANSP_COLOR));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      flush_cnt  <= 1'b0;
      first_draw <= 1'b1;
      lat_x      <= '0;
      lat_y      <= '0;
      old_x      <= '0;
      old_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lat_x <= new_x;
            lat_y <= new_y;
            busy  <= 1'b1;
            state <= first_draw ? DRAW : ERASE;
          end
        end
        ERASE: begin
          if (last) state <= DRAW;
        end
        DRAW: begin
          if (last) begin
            flush_cnt <= 1'b0;
            state     <= FLUSH;
          end
        end
        // Two cycles let the ROM read and output register drain.
        FLUSH: begin
          flush_cnt <= 1'b1;
          if (flush_cnt) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          old_x      <= lat_x;
          old_y      <= lat_y;
          first_draw <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Erase pixels go straight to the output register; draw pixels wait one
  // stage in d1 so their coordinates line up with the ROM data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d1_x       <= '0;
      d1_y       <= '0;
      d1_plot    <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      d1_x     <= x_sum[COORD_W-1:0];
      d1_y     <= y_sum[COORD_W-1:0];
      d1_plot  <= (state == DRAW) && !pix_clip;
      vga_plot <= 1'b0;
      if (state == ERASE) begin
        vga_x      <= x_sum[COORD_W-1:0];
        vga_y      <= y_sum[COORD_W-1:0];
        vga_colour <= COLOR_W'(BG_COLOR);
        vga_plot   <= !pix_clip;
      end else if (d1_plot) begin
        vga_x      <= d1_x;
        vga_y      <= d1_y;
        vga_colour <= rom_data;
        vga_plot   <= !transparent;
      end
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
//   Drives two blitters (transparency on / off) from one stimulus stream and
//   compares every plotted pixel and the done/busy timing against a simple
//   list-of-pixels model of the erase and draw rectangles.
module tb_sprite_blitter;

  localparam int N        = 100;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  typedef logic [24:0] pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] new_x = '0;
  logic [10:0] new_y = '0;
  logic        busy [2];
  logic        done [2];
  logic        vga_plot [2];
  logic [6:0]  rom_addr [2];
  logic [2:0]  rom_data [2];
  logic [2:0]  vga_colour [2];
  logic [10:0] vga_x [2];
  logic [10:0] vga_y [2];
  logic [2:0]  rom_mem [0:99];

  int checks = 0;
  int errors = 0;
  int m_old_x = 0;
  int m_old_y = 0;
  bit m_first = 1'b1;

  always #5 clk = ~clk;

  sprite_blitter #(.TRANSP_EN(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .new_x(new_x), .new_y(new_y),
    .busy(busy[0]), .done(done[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .vga_x(vga_x[0]), .vga_y(vga_y[0]), .vga_colour(vga_colour[0]), .vga_plot(vga_plot[0])
  );

  sprite_blitter #(.TRANSP_EN(0)) dut_nt (
    .clk(clk), .resetn(resetn), .start(start), .new_x(new_x), .new_y(new_y),
    .busy(busy[1]), .done(done[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .vga_x(vga_x[1]), .vga_y(vga_y[1]), .vga_colour(vga_colour[1]), .vga_plot(vga_plot[1])
  );

  // Synchronous texel ROMs, one read port per blitter.
  always @(posedge clk) begin
    rom_data[0] <= rom_mem[rom_addr[0]];
    rom_data[1] <= rom_mem[rom_addr[1]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected plot list: old footprint in BG colour (unless first draw),
  // then the on-screen, non-transparent texels of the new footprint.
  task automatic buildExpected(input int nx, input int ny, input bit te, output pix_t q[$]);
    q = {};
    if (!m_first)
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++)
          if (m_old_x + c < SCREEN_W && m_old_y + r < SCREEN_H)
            q.push_back({11'(m_old_x + c), 11'(m_old_y + r), 3'd0});
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if (nx + c < SCREEN_W && ny + r < SCREEN_H && !(te && rom_mem[r*10+c] == 3'd7))
          q.push_back({11'(nx + c), 11'(ny + r), rom_mem[r*10+c]});
  endtask

  task automatic checkPlots(input string tag, input pix_t cap[$], input pix_t exp[$]);
    int first_bad = -1;
    checkOutput({tag, " plot count"}, cap.size(), exp.size());
    for (int i = 0; i < cap.size() && i < exp.size(); i++)
      if (first_bad < 0 && cap[i] !== exp[i]) first_bad = i;
    checkOutput({tag, " first bad plot index"}, first_bad, -1);
    if (first_bad >= 0)
      checkOutput({tag, " plot {x,y,colour}"}, cap[first_bad], exp[first_bad]);
  endtask

  // One operation: start at edge 0, watch cycles 1..done+4. inj = cycle in
  // which a stray start with position (0,0) is raised; abort_cyc = cycle in
  // which reset is pulled mid-operation (-1 for none).
  task automatic applyStimulus(input string tag, input int nx, input int ny,
                               input int inj, input int abort_cyc);
    pix_t exp0[$], exp1[$], cap0[$], cap1[$];
    int exp_done;
    int done_cyc[2], done_cnt[2], busy_cnt[2], bad[2];
    buildExpected(nx, ny, 1'b1, exp0);
    buildExpected(nx, ny, 1'b0, exp1);
    exp_done = m_first ? N + 3 : 2 * N + 3;
    for (int k = 0; k < 2; k++) begin
      done_cyc[k] = -1; done_cnt[k] = 0; busy_cnt[k] = 0; bad[k] = 0;
    end
    @(negedge clk);
    start = 1'b1; new_x = 11'(nx); new_y = 11'(ny);
    @(posedge clk);
    for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (vga_plot[k] === 1'b1) begin
          if (k == 0) cap0.push_back({vga_x[k], vga_y[k], vga_colour[k]});
          else        cap1.push_back({vga_x[k], vga_y[k], vga_colour[k]});
          if (vga_x[k] >= 11'(SCREEN_W) || vga_y[k] >= 11'(SCREEN_H) || busy[k] !== 1'b1)
            bad[k]++;
        end
        if (busy[k] === 1'b1) busy_cnt[k]++;
        if (done[k] === 1'b1) begin done_cnt[k]++; done_cyc[k] = cyc; end
      end
      if (cyc == abort_cyc) begin
        checkOutput({tag, " busy before reset"}, busy[0], 1);
        resetn = 1'b0;
        #1;
        checkOutput({tag, " plot drops in reset"}, vga_plot[0], 0);
        checkOutput({tag, " busy drops in reset"}, busy[0], 0);
        checkOutput({tag, " nt plot drops in reset"}, vga_plot[1], 0);
        checkOutput({tag, " vga_x in reset"}, vga_x[0], 0);
        checkOutput({tag, " rom_addr in reset"}, rom_addr[0], 0);
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
        m_first = 1'b1; m_old_x = 0; m_old_y = 0;
        return;
      end
      start = (cyc == inj);
      if (cyc == inj) begin new_x = '0; new_y = '0; end
    end
    start = 1'b0;
    checkPlots({tag, " te1"}, cap0, exp0);
    checkPlots({tag, " te0"}, cap1, exp1);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, " done cycle"}, done_cyc[k], exp_done);
      checkOutput({tag, " done pulses"}, done_cnt[k], 1);
      checkOutput({tag, " busy cycles"}, busy_cnt[k], exp_done);
      checkOutput({tag, " bad plots"}, bad[k], 0);
    end
    m_old_x = nx; m_old_y = ny; m_first = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 100; i++) rom_mem[i] = (i % 8 == 7) ? 3'd1 : 3'(i % 8);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy[0], 0);
    checkOutput("reset done", done[0], 0);
    checkOutput("reset plot", vga_plot[0], 0);
    checkOutput("reset vga_x", vga_x[0], 0);
    checkOutput("reset vga_y", vga_y[0], 0);
    checkOutput("reset colour", vga_colour[0], 0);
    checkOutput("reset rom_addr", rom_addr[0], 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus("first draw", 20, 30, -1, -1);
    applyStimulus("move", 30, 30, 50, -1);
    applyStimulus("clip", 315, 235, -1, -1);

    for (int i = 0; i < 100; i++) rom_mem[i] = (i < 10) ? 3'd7 : 3'($urandom_range(0, 6));
    applyStimulus("transparency", 100, 100, 2 * N + 3, -1);
    applyStimulus("same position", 100, 100, -1, -1);

    applyStimulus("reset mid-draw", 50, 60, -1, N + 43);
    applyStimulus("after reset", 70, 80, -1, -1);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 100; i++) rom_mem[i] = 3'($urandom_range(0, 7));
      if (t == 3) applyStimulus("random carry", 2043, $urandom_range(0, 250), -1, -1);
      else        applyStimulus("random", $urandom_range(0, 330), $urandom_range(0, 250), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the player drawer. On each start request it erases the sprite's previous footprint to a background colour, then raster-draws a SPR_W x SPR_H sprite from an external synchronous ROM at the new position.
- Clips pixels that fall off-screen and skips transparent texels.
- Sits between the player FSMs (position + move strobe) and the VGA adapter's x/y/colour/plot interface.
- One instance per player.

Parameters:
- SPR_W, 10, sprite width in pixels
- SPR_H, 10, sprite height in pixels
- COORD_W, 11, width of x/y coordinates
- SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are clipped
- COLOR_W, 3, colour bits per pixel
- BG_COLOR, 0, colour written during erase
- TRANSP_EN, 1, 1 = texels equal to TRANSP_COLOR are not plotted
- TRANSP_COLOR, 7, transparent key colour
- ADDR_W, clog2(SPR_W*SPR_H), ROM address width (derived)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- start  in  1  draw request; sampled only in IDLE
- new_x  in  COORD_W  sprite top-left x; latched on accepted start
- new_y  in  COORD_W  sprite top-left y; latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse at end of operation
- rom_addr  out  ADDR_W  texel address = row*SPR_W + col
- rom_data  in  COLOR_W  texel colour, valid 1 cycle after rom_addr
- vga_x  out  COORD_W  pixel x
- vga_y  out  COORD_W  pixel y
- vga_colour  out  COLOR_W  pixel colour
- vga_plot  out  1  write strobe for vga_x/vga_y/vga_colour

Behaviour:
- Clock and reset: one clock, clk. Reset is resetn, asynchronous, active-low.
- Reset values:
  - state = IDLE; busy, done, vga_plot = 0.
  - vga_x, vga_y, vga_colour, rom_addr = 0.
  - old_x, old_y = 0; first_draw = 1.
- States: IDLE, ERASE, DRAW, FLUSH, DONE. Let N = SPR_W*SPR_H.
- IDLE:
  - start=1 latches new_x/new_y.
  - Next state is ERASE, or DRAW if first_draw=1.
- ERASE:
  - Walks col 0..SPR_W-1 inner, row 0..SPR_H-1 outer, one pixel per cycle, for N cycles.
  - Registered output next cycle: vga_x = old_x+col, vga_y = old_y+row, vga_colour = BG_COLOR, vga_plot = 1 unless clipped.
  - After the last pixel, the counter wraps to 0 and the state moves to DRAW.
- DRAW:
  - Same raster walk for N cycles; rom_addr = row*SPR_W+col is issued each cycle.
  - Coordinates are delayed 1 stage to align with rom_data, then registered to the vga_* outputs. Address-to-plot latency is 2 cycles.
  - vga_plot = 0 if clipped, or if TRANSP_EN and rom_data == TRANSP_COLOR.
- FLUSH: 2 cycles to drain the pipeline; the last drawn pixel appears during FLUSH.
- DONE:
  - done=1 for 1 cycle.
  - old_x/old_y <= latched new position; first_draw <= 0.
  - Then IDLE.
- Cycle budget, with start sampled at edge 0:
  - done is high in cycle 2N+3 (normal), or N+3 (first draw).
  - busy is high in cycles 1..done cycle.
- Arithmetic:
  - Coordinate sums are computed in COORD_W+1 bits.
  - Clip when the sum >= SCREEN_W (x) or >= SCREEN_H (y), including carry-out.
  - Clipped pixels still consume their cycle (fixed timing).
  - No division or modulo: row/col are separate counters, and the address is an incrementing counter.
- Boundary conditions:
  - start while busy: ignored, not queued.
  - new_x/new_y changing mid-operation: no effect.
  - start coincident with DONE: ignored; the caller must re-assert.
  - resetn low mid-operation: immediate return to IDLE. Outputs take reset values, vga_plot drops the same instant, and first_draw is re-armed.
  - new position equal to old: full erase + draw is still performed.
  - vga_plot is never high outside ERASE/DRAW/FLUSH.

Decomposition:
- Package sprite_pkg:
  - state enum (IDLE, ERASE, DRAW, FLUSH, DONE)
  - default SCREEN_W/SCREEN_H/COLOR_W constants
  - clip function (sum, limit) -> bit
- Sub-module raster_counter:
  - params W, H.
  - Ports clk, resetn, clear, step, col, row, addr, last.
  - Wraps to 0 after the last pixel.
  - Instantiated once and reused for both ERASE and DRAW.

Test Plan:
- First draw after reset:
  - Stimulus: start, new=(20,30), ROM texel = addr[2:0] with 7 remapped to 1.
  - Expected: exactly 100 plots, first at (20,30), last at (29,39).
  - Expected: no erase; done in cycle 103.
- Move:
  - Stimulus: second start, new=(30,30).
  - Expected: 100 BG plots over (20..29,30..39), then 100 sprite plots at (30..39,30..39); done in cycle 203.
- Clipping:
  - Stimulus: new=(315,235).
  - Expected: only 25 draw plots (x 315..319, y 235..239).
  - Expected: done still in cycle 203; no vga_x >= 320.
- Transparency:
  - Stimulus: ROM returns 7 at addresses 0..9.
  - Expected: row 0 not plotted, 90 plots total.
  - Stimulus: TRANSP_EN=0.
  - Expected: 100 plots.
- Ignored start:
  - Stimulus: start pulses mid-ERASE with new=(0,0).
  - Expected: no effect; old position afterwards equals the originally latched position.
- Reset mid-DRAW:
  - Stimulus: resetn low at draw pixel 40.
  - Expected: vga_plot/busy go low immediately.
  - Expected: next start does no erase (first_draw re-armed).
